load_store_unit: RTL and testbench

Byte-addressed load/store front end for the 32-bit, word-addressed data memory. Sits directly upstream of the data memory, between the pipeline's memory stage and the memory's port. Accepts one request at a time over a valid/ready handshake. Performs byte/halfword/word loads with sign or zero extension, and implements sub-word stores as read-modify-write of the containing word.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed LSU in front of a word memory: 2-cycle loads/word stores, 3-cycle RMW sub-word stores, 1-cycle errors.
// One request in flight (reqReady only in IDLE), no response backpressure; LSU_MISALIGN_TRAP_EN enables the alignment trap.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [17:0] reqAddr,
    input  logic [31:0] reqData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respErr,
    output logic        memWrite,
    output logic [15:0] memAddress,
    output logic [31:0] memDataOut,
    input  logic [31:0] memDataIn
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_STORE    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_err;
    logic [1:0]  req_size;
    logic        accept;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err  = (reqSize == 2'b11)
                    | ((reqSize == SZ_HALF) & reqAddr[0])
                    | ((reqSize == SZ_WORD) & (reqAddr[1:0] != 2'b00));
    assign req_size = reqSize;
`else
    // No trap: size 11 behaves as a word; low address bits are simply not used for the lane.
    assign req_err  = 1'b0;
    assign req_size = (reqSize == 2'b11) ? SZ_WORD : reqSize;
`endif

    assign accept = reqValid & (state_q == S_IDLE);

    // Lane extraction and merge operate on the latched request only.
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_byte = memDataIn[7:0];
            2'd1:    lane_byte = memDataIn[15:8];
            2'd2:    lane_byte = memDataIn[23:16];
            default: lane_byte = memDataIn[31:24];
        endcase
        lane_half = addr_q[1] ? memDataIn[31:16] : memDataIn[15:0];

        load_val = memDataIn;
        case (size_q)
            SZ_BYTE: load_val = {{24{sgn_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_val = {{16{sgn_q & lane_half[15]}}, lane_half};
            default: load_val = memDataIn;
        endcase

        merge_val = memDataIn;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    merge_val[7:0]   = wdata_q[7:0];
                    2'd1:    merge_val[15:8]  = wdata_q[7:0];
                    2'd2:    merge_val[23:16] = wdata_q[7:0];
                    default: merge_val[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
                else           merge_val[15:0]  = wdata_q[15:0];
            end
            default: merge_val = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    if (req_err)                 state_d = S_RESP;
                    else if (!reqWrite)          state_d = S_LOAD;
                    else if (req_size == SZ_WORD) state_d = S_STORE;
                    else                         state_d = S_RMW_READ;
                end
            end
            S_LOAD:     state_d = S_RESP;
            S_RMW_READ: state_d = S_STORE;
            S_STORE:    state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reqReady  = (state_q == S_IDLE);
        memWrite  = (state_q == S_STORE);
        respValid = (state_q == S_RESP);
        respErr   = (state_q == S_RESP) & err_q;
    end

    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        if (accept) begin
            addr_d  = reqAddr;
            size_d  = req_size;
            sgn_d   = reqSigned;
            wdata_d = reqData;
            err_d   = req_err;
            merge_d = reqData;
            rdata_d = 32'h0;
        end else if (state_q == S_LOAD) begin
            rdata_d = load_val;
        end else if (state_q == S_RMW_READ) begin
            merge_d = merge_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 18'h0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    assign memAddress = addr_q[17:2];
    assign memDataOut = merge_q;
    assign respData   = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table of single requests against a small word memory,
// plus sequences for reset during RMW and back-to-back requests with reqValid held high.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqSigned = 1'b0;
    logic [17:0] reqAddr = 18'h0;
    logic [31:0] reqData = 32'h0;
    logic        respValid;
    logic [31:0] respData;
    logic        respErr;
    logic        memWrite;
    logic [15:0] memAddress;
    logic [31:0] memDataOut;
    logic [31:0] memDataIn;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .reqSize    (reqSize),
        .reqSigned  (reqSigned),
        .reqAddr    (reqAddr),
        .reqData    (reqData),
        .respValid  (respValid),
        .respData   (respData),
        .respErr    (respErr),
        .memWrite   (memWrite),
        .memAddress (memAddress),
        .memDataOut (memDataOut),
        .memDataIn  (memDataIn)
    );

    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [31:0] pre_val = 32'h0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    int          cyc = 0;
    logic [15:0] last_wr_addr = 16'h0;

    assign memDataIn = mem[memAddress[5:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memWrite) begin
            mem[memAddress[5:0]] <= memDataOut;
            wr_cnt               <= wr_cnt + 1;
            last_wr_addr         <= memAddress;
        end else if (pre_en) begin
            mem[4] <= pre_val;
        end
        if (respValid) resp_cnt <= resp_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no DUT event within cycle budget", nm);
    endtask

    task automatic preload(input logic [31:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge clk);
        #1;
        pre_en  = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [17:0] ad, input logic [31:0] dt, input bit hold,
                          output logic [31:0] rdat, output logic rerr,
                          output int lat, output int acc_cyc);
        int n;
        reqValid  = 1'b1;
        reqWrite  = wr;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = ad;
        reqData   = dt;
        n = 0;
        while (!reqReady && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!reqReady) timeout_fail("accept_timeout");
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        chk("ready_after_accept", 32'(reqReady), 32'h0);
        if (!hold) reqValid = 1'b0;
        reqData = ~dt;
        lat = 1;
        while (!respValid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!respValid) timeout_fail("resp_timeout");
        rdat = respData;
        rerr = respErr;
        @(posedge clk);
        #1;
        chk("resp_single_pulse", 32'(respValid), 32'h0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [17:0] addr;
        logic [31:0] data;
        logic [31:0] pre;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mem;
        int          exp_wr;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat, acc, w0, r0, acc_a, acc_b, acc_c;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 2, 32'hDEADBEEF, 1};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 18'h00010, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 18'h00012, 32'h000000AA, 32'h11223344, 32'h00000000, 1'b0, 3, 32'h11AA3344, 1};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 18'h00012, 32'h0,        32'h80F07F01, 32'hFFFFFFF0, 1'b0, 2, 32'h80F07F01, 0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 18'h00012, 32'h0,        32'h80F07F01, 32'h000080F0, 1'b0, 2, 32'h80F07F01, 0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 18'h00010, 32'h0,        32'h80F07F01, 32'h00007F01, 1'b0, 2, 32'h80F07F01, 0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 18'h00012, 32'h0,        32'h80F07F01, 32'hFFFF80F0, 1'b0, 2, 32'h80F07F01, 0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 18'h00012, 32'hCAFEBEEF, 32'h11223344, 32'h00000000, 1'b0, 3, 32'hBEEF3344, 1};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 18'h00013, 32'h0,        32'h80F07F01, 32'h00000080, 1'b0, 2, 32'h80F07F01, 0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 18'h00011, 32'h000001FF, 32'h11223344, 32'h00000000, 1'b0, 3, 32'h1122FF44, 1};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{1'b0, 2'b10, 1'b0, 18'h00011, 32'h0,        32'h80F07F01, 32'h00000000, 1'b1, 1, 32'h80F07F01, 0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 18'h00013, 32'h00005555, 32'h11223344, 32'h00000000, 1'b1, 1, 32'h11223344, 0};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 18'h00010, 32'h0,        32'h80F07F01, 32'h00000000, 1'b1, 1, 32'h80F07F01, 0};
`else
        vecs[10] = '{1'b0, 2'b10, 1'b0, 18'h00011, 32'h0,        32'h80F07F01, 32'h80F07F01, 1'b0, 2, 32'h80F07F01, 0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 18'h00013, 32'h00005555, 32'h11223344, 32'h00000000, 1'b0, 3, 32'h55553344, 1};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 18'h00010, 32'h0,        32'h80F07F01, 32'h80F07F01, 1'b0, 2, 32'h80F07F01, 0};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_reqReady",   32'(reqReady),  32'h1);
        chk("rst_respValid",  32'(respValid), 32'h0);
        chk("rst_respData",   respData,       32'h0);
        chk("rst_respErr",    32'(respErr),   32'h0);
        chk("rst_memWrite",   32'(memWrite),  32'h0);
        chk("rst_memAddress", 32'(memAddress), 32'h0);
        chk("rst_memDataOut", memDataOut,     32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            preload(vecs[i].pre);
            w0 = wr_cnt;
            do_req(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].data, 1'b0,
                   rd, re, lat, acc);
            chk($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
            chk($sformatf("v%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
            chk($sformatf("v%0d_mem4", i), mem[4], vecs[i].exp_mem);
            if (vecs[i].exp_wr > 0)
                chk($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'h4);
        end

        // Reset while the byte-store read phase is in progress.
        preload(32'h11223344);
        w0 = wr_cnt;
        r0 = resp_cnt;
        reqValid  = 1'b1;
        reqWrite  = 1'b1;
        reqSize   = 2'b00;
        reqSigned = 1'b0;
        reqAddr   = 18'h00012;
        reqData   = 32'h000000AA;
        @(posedge clk);
        #1;
        chk("rmwrst_busy", 32'(reqReady), 32'h0);
        reqValid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rmwrst_memWrite_async", 32'(memWrite), 32'h0);
        chk("rmwrst_ready_in_reset", 32'(reqReady), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rmwrst_mem4", mem[4], 32'h11223344);
        chk("rmwrst_writes", 32'(wr_cnt - w0), 32'h0);
        chk("rmwrst_resps", 32'(resp_cnt - r0), 32'h0);
        chk("rmwrst_ready", 32'(reqReady), 32'h1);

        // Back-to-back with reqValid held high.
        preload(32'h01020304);
        r0 = resp_cnt;
        do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 1'b1, rd, re, lat, acc_a);
        chk("b2b_a_data", rd, 32'h01020304);
        do_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'h55667788, 1'b1, rd, re, lat, acc_b);
        chk("b2b_b_data", rd, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 18'h00013, 32'h0, 1'b1, rd, re, lat, acc_c);
        reqValid = 1'b0;
        chk("b2b_c_data", rd, 32'h00000055);
        chk("b2b_interval_ab", 32'(acc_b - acc_a), 32'h3);
        chk("b2b_interval_bc", 32'(acc_c - acc_b), 32'h3);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_resp_count", 32'(resp_cnt - r0), 32'h3);
        chk("b2b_mem4", mem[4], 32'h55667788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
